// File: rtl/irq_ctrl_pkg.sv
// irq_ctrl_pkg: shared constants for the interrupt controller.
// Holds the bridge address and register offsets, the FSM state encoding,
// the peripheral source indices and a byte-enable expansion helper.
package irq_ctrl_pkg;

  // Bridge window base; the controller decodes addr[3:2] inside it
  localparam logic [31:0] IRQ_BASE_ADDR = 32'h7f20;

  // Word offsets inside the window
  localparam logic [1:0] OFF_PENDING = 2'd0;
  localparam logic [1:0] OFF_MASK    = 2'd1;
  localparam logic [1:0] OFF_STATUS  = 2'd2;
  localparam logic [1:0] OFF_STATS   = 2'd3;

  // Arbitration FSM encoding
  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACTIVE = 1'b1;

  // Source indices as wired on the board
  localparam int SRC_TIMER0 = 0;
  localparam int SRC_TIMER1 = 1;
  localparam int SRC_EXT    = 2;

  // Width of the in-service index (enough for up to 8 sources)
  localparam int IRQ_ID_W = 3;

  // Expand 4 byte enables into a 32-bit bit mask
  function automatic logic [31:0] be_to_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/irq_ctrl_prio_enc.sv
// irq_prio_enc: combinational lowest-index-wins priority encoder.
// o_valid is high when any request is set; o_id is the lowest set index.
module irq_prio_enc
  import irq_ctrl_pkg::*;
#(
  parameter int N = 6
) (
  input  logic [N-1:0]          i_req,
  output logic                  o_valid,
  output logic [IRQ_ID_W-1:0]   o_id
);

  // Scan from the top down so the lowest set index is the last one written
  always_comb begin
    o_valid = 1'b0;
    o_id    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_valid = 1'b1;
        o_id    = IRQ_ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: memory-mapped interrupt controller feeding CP0 HWInt.
// Latches source events as pending bits, masks them and keeps one source
// in service at a time, presented to CP0 as a registered one-hot vector.
// Optional feature: define IRQ_STATS_EN to add the ACK statistics counter
// at word offset 3; without it that offset reads 0 and ignores writes.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int               N_SRC     = 6,
  parameter logic [N_SRC-1:0] EDGE_MASK = 6'b000100,
  parameter logic [N_SRC-1:0] MASK_RST  = 6'b111111
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_SRC-1:0]  src_irq,
  input  logic              sel,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  input  logic [3:0]        byteen,
  output logic [31:0]       rdata,
  output logic [N_SRC-1:0]  hw_int,
  output logic [2:0]        irq_id,
  output logic              irq_active
);

  logic [N_SRC-1:0]    r_pending;
  logic [N_SRC-1:0]    r_prev_src;
  logic [N_SRC-1:0]    r_mask;
  logic [0:0]          r_state;
  logic [IRQ_ID_W-1:0] r_irq_id;
  logic [N_SRC-1:0]    r_hw_int;

  logic                w_write;
  logic [1:0]          w_off;
  logic [31:0]         w_be_mask;
  logic [31:0]         w_wdata_be;
  logic [N_SRC-1:0]    w_ack_clr;
  logic [N_SRC-1:0]    w_set;
  logic [N_SRC-1:0]    w_pending_nxt;
  logic [N_SRC-1:0]    w_mask_nxt;
  logic [N_SRC-1:0]    w_eligible;
  logic [7:0]          w_elig_ext;
  logic [7:0]          w_pend_ext;
  logic                w_cur_elig;
  logic                w_enc_valid;
  logic [IRQ_ID_W-1:0] w_enc_id;
  logic [0:0]          w_state_nxt;
  logic [IRQ_ID_W-1:0] w_id_nxt;
  logic [N_SRC-1:0]    w_onehot_nxt;
  logic                w_unused;

  // Bus decode: a store is any selected access with a byte enable set
  assign w_write    = sel & (|byteen);
  assign w_off      = addr[3:2];
  assign w_be_mask  = be_to_mask(byteen);
  assign w_wdata_be = wdata & w_be_mask;

  // ACK clears only bits whose byte lane was enabled
  assign w_ack_clr = (w_write && (w_off == OFF_PENDING)) ? w_wdata_be[N_SRC-1:0] : '0;

  // Edge sources latch on a rising transition, level sources while high
  assign w_set = (src_irq & ~r_prev_src & EDGE_MASK) | (src_irq & ~EDGE_MASK);

  // Set wins over a same-edge clear so no event is lost
  assign w_pending_nxt = (r_pending & ~w_ack_clr) | w_set;

  // Mask writes only touch bits in enabled byte lanes
  assign w_mask_nxt = (w_write && (w_off == OFF_MASK))
                    ? ((r_mask & ~w_be_mask[N_SRC-1:0]) | w_wdata_be[N_SRC-1:0])
                    : r_mask;

  assign w_eligible = r_pending & r_mask;

  // Widen eligible/pending to 8 bits so the id can index them safely
  always_comb begin
    w_elig_ext = '0;
    w_pend_ext = '0;
    w_elig_ext[N_SRC-1:0] = w_eligible;
    w_pend_ext[N_SRC-1:0] = r_pending;
  end

  assign w_cur_elig = w_elig_ext[r_irq_id];

  irq_prio_enc #(
    .N (N_SRC)
  ) u_prio_enc (
    .i_req   (w_eligible),
    .o_valid (w_enc_valid),
    .o_id    (w_enc_id)
  );

  // Arbitration: pick a source from IDLE, hold it while ACTIVE, and
  // re-arbitrate only once the in-service source stops being eligible
  always_comb begin
    w_state_nxt = r_state;
    w_id_nxt    = r_irq_id;
    if (r_state == IDLE) begin
      if (w_enc_valid) begin
        w_state_nxt = ACTIVE;
        w_id_nxt    = w_enc_id;
      end
    end else if (!w_cur_elig) begin
      if (w_enc_valid) begin
        w_id_nxt = w_enc_id;
      end else begin
        w_state_nxt = IDLE;
      end
    end
  end

  // One-hot presentation of the next in-service source, zero when idle
  always_comb begin
    w_onehot_nxt = '0;
    for (int i = 0; i < N_SRC; i++) begin
      w_onehot_nxt[i] = (w_state_nxt == ACTIVE) && (w_id_nxt == IRQ_ID_W'(i));
    end
  end

  // Pending, edge history and mask registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pending  <= '0;
      r_prev_src <= '0;
      r_mask     <= MASK_RST;
    end else begin
      r_pending  <= w_pending_nxt;
      r_prev_src <= src_irq;
      r_mask     <= w_mask_nxt;
    end
  end

  // FSM state and registered CP0-facing outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_irq_id <= '0;
      r_hw_int <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_irq_id <= w_id_nxt;
      r_hw_int <= w_onehot_nxt;
    end
  end

  assign hw_int     = r_hw_int;
  assign irq_id     = r_irq_id;
  assign irq_active = (r_state == ACTIVE);

`ifdef IRQ_STATS_EN
  logic [31:0] r_stats;
  logic        w_ack_leave;

  // A departure from the in-service source counts only when its pending
  // bit is gone; a masked-but-pending source is not an acknowledgement
  assign w_ack_leave = (r_state == ACTIVE) && !w_cur_elig && !w_pend_ext[r_irq_id];

  // Statistics counter: any store to its offset clears it, else count ACKs
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_stats <= '0;
    end else if (w_write && (w_off == OFF_STATS)) begin
      r_stats <= '0;
    end else if (w_ack_leave) begin
      r_stats <= r_stats + 32'd1;
    end
  end
`endif

  // Side-effect-free read mux; unused bits read as zero
  always_comb begin
    rdata = '0;
    case (w_off)
      OFF_PENDING: rdata[N_SRC-1:0] = r_pending;
      OFF_MASK:    rdata[N_SRC-1:0] = r_mask;
      OFF_STATUS:  rdata = {(r_state == ACTIVE), 28'b0, r_irq_id};
`ifdef IRQ_STATS_EN
      OFF_STATS:   rdata = r_stats;
`else
      OFF_STATS:   rdata = '0;
`endif
      default:     rdata = '0;
    endcase
  end

  // Address and data bits outside the decoded fields are intentionally dropped
  assign w_unused = ^{addr[31:4], addr[1:0], w_wdata_be[31:N_SRC], w_pend_ext};

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed self-checking bench for irq_ctrl.
// Drives stores and source pulses one cycle at a time and compares the
// registered outputs and read data against hand-computed values.
// Define IRQ_STATS_EN for both bench and RTL to exercise the counter.
module tb_irq_ctrl;
  import irq_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  src_irq;
  logic        sel;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  byteen;
  logic [31:0] rdata;
  logic [5:0]  hw_int;
  logic [2:0]  irq_id;
  logic        irq_active;

  int checkCount = 0;
  int errorCount = 0;

  // 10 ns clock
  always #5 clk = ~clk;

  irq_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .src_irq    (src_irq),
    .sel        (sel),
    .addr       (addr),
    .wdata      (wdata),
    .byteen     (byteen),
    .rdata      (rdata),
    .hw_int     (hw_int),
    .irq_id     (irq_id),
    .irq_active (irq_active)
  );

  // Single comparison point: count it and report a mismatch
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and settle 1 ns past the last one
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One store cycle on the bridge, landing on the next rising edge
  task automatic applyStimulus(input logic [1:0] off, input logic [31:0] data, input logic [3:0] be);
    sel    = 1'b1;
    addr   = {IRQ_BASE_ADDR[31:4], off, 2'b00};
    wdata  = data;
    byteen = be;
    tick(1);
    sel    = 1'b0;
    byteen = 4'h0;
    wdata  = '0;
  endtask

  // Combinational read, no clock edge consumed
  task automatic readReg(input logic [1:0] off, input logic [31:0] exp, input string tag);
    sel    = 1'b1;
    byteen = 4'h0;
    addr   = {IRQ_BASE_ADDR[31:4], off, 2'b00};
    #1;
    checkOutput(tag, rdata, exp);
    sel    = 1'b0;
  endtask

  // Check hw_int and irq_active together
  task automatic checkOuts(input string tag, input logic [5:0] expHw, input logic expAct);
    checkOutput({tag, "_hw"}, {26'b0, hw_int}, {26'b0, expHw});
    checkOutput({tag, "_act"}, {31'b0, irq_active}, {31'b0, expAct});
  endtask

  // Raise one source for a cycle, confirm it goes in service, then ACK it
  task automatic fireAndAck(input int idx);
    src_irq = 6'(1 << idx);
    tick(1);
    src_irq = '0;
    tick(1);
    checkOutput("fire_id", {29'b0, irq_id}, 32'(idx));
    applyStimulus(OFF_PENDING, 32'(1 << idx), 4'hf);
    tick(1);
    checkOutput("fire_done_hw", {26'b0, hw_int}, 32'h0);
  endtask

  // Guard against a hung run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  // Directed sequence
  initial begin
    reset   = 1'b0;
    src_irq = '0;
    sel     = 1'b0;
    addr    = '0;
    wdata   = '0;
    byteen  = 4'h0;
    tick(2);
    reset = 1'b1;

    // Reset state
    readReg(OFF_MASK, 32'h3f, "rst_mask");
    readReg(OFF_PENDING, 32'h0, "rst_pend");
    readReg(OFF_STATUS, 32'h0, "rst_status");
    checkOuts("rst", 6'h00, 1'b0);
    checkOutput("rst_id", {29'b0, irq_id}, 32'h0);

    // Edge pulse on the external pin, then ACK
    src_irq = 6'b000100;
    tick(1);
    src_irq = '0;
    readReg(OFF_PENDING, 32'h04, "edge_pend");
    checkOutput("edge_hw_early", {26'b0, hw_int}, 32'h0);
    tick(1);
    checkOuts("edge_act", 6'b000100, 1'b1);
    checkOutput("edge_id", {29'b0, irq_id}, 32'd2);
    readReg(OFF_STATUS, 32'h8000_0002, "edge_status");
    applyStimulus(OFF_PENDING, 32'h4, 4'hf);
    readReg(OFF_PENDING, 32'h0, "ack_pend");
    checkOutput("ack_hw_hold", {26'b0, hw_int}, 32'h04);
    tick(1);
    checkOuts("ack_done", 6'h00, 1'b0);

    // No preemption, then re-arbitration without an idle gap
    src_irq = 6'b000100;
    tick(1);
    src_irq = 6'b000010;
    tick(1);
    checkOutput("nopre_id0", {29'b0, irq_id}, 32'd2);
    src_irq = 6'b000011;
    tick(2);
    checkOutput("nopre_id", {29'b0, irq_id}, 32'd2);
    readReg(OFF_PENDING, 32'h07, "nopre_pend");
    applyStimulus(OFF_PENDING, 32'h4, 4'hf);
    checkOutput("rearb_hold_act", {31'b0, irq_active}, 32'h1);
    tick(1);
    checkOuts("rearb0", 6'b000001, 1'b1);
    checkOutput("rearb0_id", {29'b0, irq_id}, 32'd0);
    src_irq = 6'b000010;
    applyStimulus(OFF_PENDING, 32'h1, 4'hf);
    tick(1);
    checkOuts("rearb1", 6'b000010, 1'b1);
    checkOutput("rearb1_id", {29'b0, irq_id}, 32'd1);
    src_irq = '0;
    applyStimulus(OFF_PENDING, 32'h2, 4'hf);
    tick(1);
    checkOuts("rearb_idle", 6'h00, 1'b0);
    readReg(OFF_PENDING, 32'h0, "rearb_pend");

    // New edge on the same edge as its ACK: set wins
    src_irq = 6'b000100;
    tick(1);
    src_irq = '0;
    tick(1);
    checkOutput("same_id", {29'b0, irq_id}, 32'd2);
    src_irq = 6'b000100;
    applyStimulus(OFF_PENDING, 32'h4, 4'hf);
    src_irq = '0;
    readReg(OFF_PENDING, 32'h04, "same_pend");
    tick(1);
    checkOuts("same_hw", 6'b000100, 1'b1);
    applyStimulus(OFF_PENDING, 32'h4, 4'hf);
    tick(1);
    checkOuts("same_done", 6'h00, 1'b0);

    // ACK ignored when byte lane 0 is disabled
    src_irq = 6'b000100;
    tick(1);
    src_irq = '0;
    tick(1);
    applyStimulus(OFF_PENDING, 32'h4, 4'he);
    readReg(OFF_PENDING, 32'h04, "be_ack_pend");
    tick(1);
    checkOuts("be_ack_hw", 6'b000100, 1'b1);

    // Masking the in-service source
    applyStimulus(OFF_MASK, 32'h3b, 4'hf);
    checkOutput("mask_hw_hold", {26'b0, hw_int}, 32'h04);
    tick(1);
    checkOuts("mask_off", 6'h00, 1'b0);
    readReg(OFF_PENDING, 32'h04, "mask_pend");
    readReg(OFF_MASK, 32'h3b, "mask_rd");
    applyStimulus(OFF_MASK, 32'h0, 4'he);
    readReg(OFF_MASK, 32'h3b, "mask_be");
    applyStimulus(OFF_MASK, 32'hffff_ffff, 4'hf);
    readReg(OFF_MASK, 32'h3f, "mask_wide");
    tick(1);
    checkOuts("mask_on", 6'b000100, 1'b1);
    checkOutput("mask_on_id", {29'b0, irq_id}, 32'd2);

    // Reset while ACTIVE
    reset = 1'b0;
    tick(1);
    checkOuts("rst_mid", 6'h00, 1'b0);
    checkOutput("rst_mid_id", {29'b0, irq_id}, 32'h0);
    reset = 1'b1;
    readReg(OFF_PENDING, 32'h0, "rst_mid_pend");
    readReg(OFF_MASK, 32'h3f, "rst_mid_mask");

    // Level source re-pends while still high
    src_irq = 6'b000001;
    tick(2);
    checkOuts("lvl_act", 6'b000001, 1'b1);
    applyStimulus(OFF_PENDING, 32'h1, 4'hf);
    readReg(OFF_PENDING, 32'h01, "lvl_repend");
    tick(1);
    checkOuts("lvl_hold", 6'b000001, 1'b1);
    src_irq = '0;
    applyStimulus(OFF_PENDING, 32'h1, 4'hf);
    tick(1);
    checkOuts("lvl_done", 6'h00, 1'b0);

`ifdef IRQ_STATS_EN
    // ACK statistics counter
    applyStimulus(OFF_STATS, 32'h0, 4'hf);
    readReg(OFF_STATS, 32'h0, "stats_clr0");
    fireAndAck(SRC_TIMER0);
    fireAndAck(SRC_TIMER1);
    fireAndAck(SRC_EXT);
    readReg(OFF_STATS, 32'd3, "stats_three");
    src_irq = 6'b000100;
    tick(1);
    src_irq = '0;
    tick(1);
    applyStimulus(OFF_MASK, 32'h3b, 4'hf);
    tick(1);
    checkOuts("stats_mask", 6'h00, 1'b0);
    readReg(OFF_STATS, 32'd3, "stats_masked");
    applyStimulus(OFF_MASK, 32'h3f, 4'hf);
    tick(1);
    applyStimulus(OFF_PENDING, 32'h4, 4'hf);
    tick(1);
    readReg(OFF_STATS, 32'd4, "stats_four");
    applyStimulus(OFF_STATS, 32'h1234, 4'hf);
    readReg(OFF_STATS, 32'h0, "stats_clr");
`else
    // Offset 3 is inert without the counter
    fireAndAck(SRC_TIMER0);
    applyStimulus(OFF_STATS, 32'hffff_ffff, 4'hf);
    readReg(OFF_STATS, 32'h0, "stats_absent");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
Memory-mapped interrupt controller between the peripherals (Timer0, Timer1, external interrupt pin) and CP0's HWInt inputs. It latches source events as pending bits, masks them, and arbitrates to one in-service source at a time. It presents that source to CP0 as a one-hot hw_int vector. It sits on the bridge at base 0x7f20: the handler acknowledges with a store to 0x7f20 and reads status over the same word-addressed window.

Parameters:
N_SRC, 6, number of interrupt sources (matches CP0 HWInt width, ≤8)
EDGE_MASK, 6'b000100, per-source: 1 = rising-edge triggered, 0 = level triggered
MASK_RST, 6'b111111, reset value of MASK register

Ports:
clk  input  1  system clock
reset  input  1  synchronous active-low reset; state clears on the clk edge while reset==0
src_irq  input  N_SRC  raw source requests (bit0 Timer0, bit1 Timer1, bit2 external)
sel  input  1  bridge select for the 0x7f20–0x7f2f window
addr  input  32  byte address; only addr[3:2] decoded
wdata  input  32  store data
byteen  input  4  store byte enables; write = sel && |byteen
rdata  output  32  combinational read data
hw_int  output  N_SRC  one-hot in-service source to CP0, registered
irq_id  output  3  index of in-service source, registered
irq_active  output  1  FSM in ACTIVE, registered

Behaviour:
- Register map (word offset addr[3:2]):
  - 0 PENDING: read pending; write is W1C ACK.
  - 1 MASK: RW.
  - 2 STATUS: RO {irq_active at bit31, irq_id at [2:0]}.
  - 3 STATS (optional feature); 0 otherwise.
  - Unused bits read 0.
- Reset (reset==0 at edge): pending=0, prev_src=0, mask=MASK_RST, state=IDLE, hw_int=0, irq_id=0, irq_active=0.
- Event capture, each edge:
  - Edge source: set when src_irq & ~prev_src.
  - Level source: set when src_irq high.
  - prev_src <= src_irq.
- ACK: write to offset 0 clears pending[i] where wdata[i]=1, only for bytes with byteen set.
  - Any store hitting 0x7f20 with wdata bit set counts.
  - Same-edge set and clear of one bit: set wins; no event lost.
- MASK write honours byteen per byte; bits ≥N_SRC ignored.
- eligible = pending & mask. Priority: lowest index wins.
- FSM:
  - IDLE: if eligible≠0, go ACTIVE, latch irq_id = prio(eligible).
  - ACTIVE: hold irq_id, no preemption. If eligible[irq_id]==0 (acked or masked), re-arbitrate on that edge. If other eligible bits remain, stay ACTIVE with the new id; else go IDLE.
- Outputs: hw_int = ACTIVE ? onehot(irq_id) : 0. irq_active = (state==ACTIVE). All are registered.
- Latency:
  - Edge-source rises before edge E: pending set at E, hw_int asserted after E+1.
  - ACK store at edge A: pending clears at A, hw_int drops or moves after A+1.
- A level source held high re-pends immediately after ACK; software must clear it at the peripheral first.
- Reset mid-ACTIVE: hw_int drops on that edge; no stale pending survives.
- Reads have no side effects.

Optional Feature:
- Macro IRQ_STATS_EN.
- Defined: 32-bit STATS counter at offset 3, +1 on each ACTIVE→(IDLE or new id) transition caused by ACK (not by masking). It wraps 0xffffffff→0, reset 0, and a write of any value clears it to 0.
- Undefined: offset 3 reads 0, writes ignored, no counter flops.

Decomposition:
- Package irq_ctrl_pkg holds:
  - register offsets OFF_PENDING=2'd0, OFF_MASK=2'd1, OFF_STATUS=2'd2, OFF_STATS=2'd3
  - base address 32'h7f20
  - FSM state encoding IDLE/ACTIVE
  - source index constants SRC_TIMER0/1/EXT
- One sub-module irq_prio_enc: combinational lowest-index priority encoder, output {valid, id}.

Test Plan:
- Reset, then read → MASK reads 0x3f, PENDING 0, STATUS 0, hw_int=0.
- Pulse src_irq[2] one cycle → pending=0x04 next edge, hw_int=6'b000100, irq_id=2 one edge later; store 0x4 to 0x7f20 with byteen=4'hf → hw_int=0 one edge after store.
- Hold src_irq[1] and src_irq[2] pending while ACTIVE on id 2, then raise src_irq[0] → id stays 2. ACK bit2 → id becomes 0, no IDLE cycle. ACK bit0 → id 1.
- Edge on src_irq[2] in the same cycle as an ACK writing 0x4 → pending[2] stays 1, hw_int re-asserts.
- MASK=0x3b with pending[2] set → hw_int=0 and PENDING reads 0x04. MASK=0x3f → hw_int=0x04 after one edge. Pull reset low mid-ACTIVE → all outputs 0 next edge.
- With IRQ_STATS_EN: three ACKed interrupts → STATS=3; a write to offset 3 → STATS=0; masking the active source does not increment.
